ddr_wr_packer: RTL



---
 rtl/ddr_wr_packer_pkg.sv | 21 ++
 rtl/ddr_wr_packer_quant.sv | 49 ++++
 rtl/ddr_wr_packer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ddr_wr_packer_pkg.sv
// Shared types and helpers for the DDR write-back packer.
package ddr_wr_packer_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DDR_W_DEF  = 256;
    localparam int LANES      = DDR_W_DEF / DATA_W_DEF;

    typedef logic [DDR_W_DEF-1:0] ddr_word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } wr_state_t;

    function automatic int bw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr_wr_packer_quant.sv
// Requantizer: arithmetic right shift of a signed result, then saturation to DATA_W.
// Round-half-up before the shift when ROUND_NEAREST_EN is defined.
module quant_sat #(
    parameter int RES_W   = 32,
    parameter int DATA_W  = 8,
    parameter int SHIFT_W = 5
) (
    input  logic signed [RES_W-1:0]  din,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [DATA_W-1:0] dout
);

`ifdef ROUND_NEAREST_EN
    function automatic logic signed [RES_W:0] rnd_half_up(input logic signed [RES_W:0] x,
                                                          input logic [SHIFT_W-1:0] s);
        logic signed [RES_W:0] bias;
        bias = '0;
        if (s != '0) bias[s - 1'b1] = 1'b1;
        return x + bias;
    endfunction
`endif

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [RES_W:0] x);
        logic signed [RES_W:0] hi;
        logic signed [RES_W:0] lo;
        hi = {{(RES_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
        lo = {{(RES_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};
        if (x > hi)
            return hi[DATA_W-1:0];
        else if (x < lo)
            return lo[DATA_W-1:0];
        else
            return x[DATA_W-1:0];
    endfunction

    logic signed [RES_W:0] ext;
    logic signed [RES_W:0] shd;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        ext = {din[RES_W-1], din};
`ifdef ROUND_NEAREST_EN
        ext = rnd_half_up(ext, shift);
`endif
        shd  = ext >>> shift;
        dout = sat(shd);
    end

endmodule

// File: rtl/ddr_wr_packer.sv
// Requantizes a signed result stream, packs DDR_W/DATA_W lanes per word and issues one
// write burst per start. Optional round-half-up requantization via ROUND_NEAREST_EN.
module ddr_wr_packer
    import ddr_wr_packer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int RES_W      = 32,
    parameter int DDR_W      = 256,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DDR_ADDR_W-1:0]   cfg_addr,
    input  logic [BURST_W-1:0]      cfg_len,
    input  logic [bw(RES_W)-1:0]    cfg_shift,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [RES_W-1:0] in_data,
    output logic                    wr_req,
    input  logic                    wr_req_ready,
    output logic [DDR_ADDR_W-1:0]   wr_addr,
    output logic [BURST_W-1:0]      wr_len,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [DDR_W-1:0]        wr_data,
    output logic                    wr_last,
    output logic                    busy,
    output logic                    done
);

    localparam int NL      = DDR_W / DATA_W;
    localparam int LANE_W  = bw(NL);
    localparam int SHIFT_W = bw(RES_W);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NL - 1);

    wr_state_t                state;
    logic [LANE_W-1:0]        lane;
    logic [BURST_W-1:0]       in_words;
    logic [SHIFT_W-1:0]       shift_q;
    logic [DDR_W-1:0]         pack_p0;
    logic [DDR_W-1:0]         word_full;
    logic signed [DATA_W-1:0] q;
    logic                     acc;
    logic                     drain;
    logic                     lane_last;

    quant_sat #(
        .RES_W  (RES_W),
        .DATA_W (DATA_W),
        .SHIFT_W(SHIFT_W)
    ) u_quant (
        .din  (in_data),
        .shift(shift_q),
        .dout (q)
    );

    assign lane_last = (lane == LAST_LANE);
    assign drain     = wr_valid & wr_ready;
    assign in_ready  = (state == DATA) && (in_words < wr_len) &&
                       (!lane_last || !wr_valid || wr_ready);
    assign acc       = in_valid & in_ready;
    assign busy      = (state != IDLE);

    // The final lane bypasses the pack register straight into the output word.
    always_comb begin
        word_full = pack_p0;
        word_full[DDR_W-DATA_W +: DATA_W] = q;
    end

    // Stage p0: pack register, every lane is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (acc) pack_p0[lane*DATA_W +: DATA_W] <= q;
    end

    // Stage p1: control FSM and output word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_req   <= 1'b0;
            wr_addr  <= '0;
            wr_len   <= '0;
            shift_q  <= '0;
            lane     <= '0;
            in_words <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
            wr_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            wr_addr  <= cfg_addr;
                            wr_len   <= cfg_len;
                            shift_q  <= cfg_shift;
                            lane     <= '0;
                            in_words <= '0;
                            wr_req   <= 1'b1;
                            state    <= REQ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (wr_req_ready) begin
                        wr_req <= 1'b0;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (acc) begin
                        if (lane_last) begin
                            lane     <= '0;
                            in_words <= in_words + 1'b1;
                            wr_valid <= 1'b1;
                            wr_data  <= word_full;
                            wr_last  <= (in_words == wr_len - 1'b1);
                        end else begin
                            lane <= lane + 1'b1;
                        end
                    end
                    if (drain && !(acc && lane_last)) begin
                        wr_valid <= 1'b0;
                        wr_last  <= 1'b0;
                    end
                    if (drain && wr_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
